// File: rtl/mem_data_responder_pkg.sv
// Shared encodings for the data-memory responder: FSM states, access sizes
// and the alignment rule applied to incoming requests.
package mem_data_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Reserved size is reported through the same error path as misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_HALF: return lane[0];
      SZ_WORD: return (lane != 2'b00);
      SZ_RSVD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_datos.sv
// Single-port block RAM, read-first, registered read. LOW_LATENCY gives one
// cycle of read latency; HIGH_PERFORMANCE adds an output register.
module ram_datos #(
  parameter int RAM_WIDTH       = 32,
  parameter int RAM_DEPTH       = 2048,
  parameter     RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                         clk,
  input  logic [$clog2(RAM_DEPTH)-1:0] addr,
  input  logic [RAM_WIDTH-1:0]         din,
  input  logic                         we,
  input  logic                         en,
  output logic [RAM_WIDTH-1:0]         dout
);

  logic [RAM_WIDTH-1:0] mem [0:RAM_DEPTH-1];
  logic [RAM_WIDTH-1:0] ram_data_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      ram_data_reg <= mem[addr];
    end
  end

  generate
    if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_out_reg
      logic [RAM_WIDTH-1:0] dout_reg;
      always_ff @(posedge clk) begin
        dout_reg <= ram_data_reg;
      end
      assign dout = dout_reg;
    end else begin : g_no_out_reg
      assign dout = ram_data_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_data_responder.sv
// Load/store responder in front of a word-wide data RAM: handles byte/half/word
// accesses, read-modify-write for partial stores, and load extension.
module mem_data_responder
  import mem_data_responder_pkg::*;
#(
  parameter int LEN       = 32,
  parameter int RAM_DEPTH = 2048,
  parameter int NB_SIZE   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [LEN-1:0]     i_req_addr,
  input  logic [LEN-1:0]     i_req_wdata,
  input  logic               i_req_write,
  input  logic [NB_SIZE-1:0] i_req_size,
  input  logic               i_req_unsigned,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [LEN-1:0]     o_rsp_rdata,
  output logic               o_rsp_err,
  output logic               o_busy
);

  localparam int AW = $clog2(RAM_DEPTH);

  state_t state_reg, state_next;

  logic [AW+1:0]  addr_reg;
  logic [LEN-1:0] wdata_reg;
  logic           write_reg;
  logic [1:0]     size_reg;
  logic           unsigned_reg;
  logic           err_reg;

  logic           rsp_valid_reg;
  logic [LEN-1:0] rsp_rdata_reg;
  logic           rsp_err_reg;

  logic           req_err;
  logic           ram_en;
  logic           ram_we;
  logic [LEN-1:0] ram_din;
  logic [LEN-1:0] ram_dout;
  logic [LEN-1:0] load_data;
  logic [7:0]     byte_lane;
  logic [15:0]    half_lane;

  assign req_err = is_misaligned(i_req_size[1:0], i_req_addr[1:0]);

  // Address bits above the word index are deliberately ignored so accesses wrap.
  generate
    if (LEN > AW + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^i_req_addr[LEN-1:AW+2];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    o_req_ready = 1'b0;
    o_busy      = 1'b1;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) begin
          if (req_err) begin
            state_next = ST_RSP;
          end else if (!i_req_write) begin
            state_next = ST_RD;
          end else if (i_req_size[1:0] == SZ_WORD) begin
            state_next = ST_WR;
          end else begin
            state_next = ST_RD;
          end
        end
      end
      ST_RD: begin
        ram_en     = ~i_rst;
        state_next = write_reg ? ST_WR : ST_RSP;
      end
      ST_WR: begin
        // Gating with reset keeps a reset in this cycle from committing the write.
        ram_en     = ~i_rst;
        ram_we     = ~i_rst;
        state_next = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_valid_reg && i_rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      write_reg     <= 1'b0;
      size_reg      <= SZ_BYTE;
      unsigned_reg  <= 1'b0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && i_req_valid) begin
        addr_reg     <= i_req_addr[AW+1:0];
        wdata_reg    <= i_req_wdata;
        write_reg    <= i_req_write;
        size_reg     <= i_req_size[1:0];
        unsigned_reg <= i_req_unsigned;
        err_reg      <= req_err;
      end
      // The response is captured on the first RSP cycle, when RAM output is settled.
      if (state_reg == ST_RSP && !rsp_valid_reg) begin
        rsp_valid_reg <= 1'b1;
        rsp_rdata_reg <= (err_reg || write_reg) ? '0 : load_data;
        rsp_err_reg   <= err_reg;
      end else if (rsp_valid_reg && i_rsp_ready) begin
        rsp_valid_reg <= 1'b0;
        rsp_rdata_reg <= '0;
        rsp_err_reg   <= 1'b0;
      end
    end
  end

  assign byte_lane = ram_dout[{addr_reg[1:0], 3'b000} +: 8];
  assign half_lane = ram_dout[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_data = ram_dout;
    case (size_reg)
      SZ_BYTE: load_data = {{(LEN-8){byte_lane[7] & ~unsigned_reg}}, byte_lane};
      SZ_HALF: load_data = {{(LEN-16){half_lane[15] & ~unsigned_reg}}, half_lane};
      default: load_data = ram_dout;
    endcase
  end

  // Partial stores merge into the old word read during the preceding RD cycle.
  always_comb begin
    ram_din = ram_dout;
    case (size_reg)
      SZ_BYTE: ram_din[{addr_reg[1:0], 3'b000} +: 8]  = wdata_reg[7:0];
      SZ_HALF: ram_din[{addr_reg[1], 4'b0000} +: 16] = wdata_reg[15:0];
      default: ram_din = wdata_reg;
    endcase
  end

  ram_datos #(
    .RAM_WIDTH      (LEN),
    .RAM_DEPTH      (RAM_DEPTH),
    .RAM_PERFORMANCE("LOW_LATENCY")
  ) u_ram_datos (
    .clk (i_clk),
    .addr(addr_reg[AW+1:2]),
    .din (ram_din),
    .we  (ram_we),
    .en  (ram_en),
    .dout(ram_dout)
  );

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_rdata = rsp_rdata_reg;
  assign o_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_mem_data_responder.sv
// Randomized and directed checks of mem_data_responder against a word-array
// memory model with byte/half lane arithmetic.
module tb_mem_data_responder;

  localparam int LEN   = 32;
  localparam int DEPTH = 2048;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_write;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_busy;

  int comp_cnt = 0;
  int fail_cnt = 0;

  logic [31:0] mem_model [0:DEPTH-1];

  mem_data_responder #(.LEN(LEN), .RAM_DEPTH(DEPTH), .NB_SIZE(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_wdata   (i_req_wdata),
    .i_req_write   (i_req_write),
    .i_req_size    (i_req_size),
    .i_req_unsigned(i_req_unsigned),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference behaviour: returns expected response and updates the model memory.
  function automatic void model_op(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                                   input logic [1:0] sz, input logic uns,
                                   output logic [31:0] exp_data, output logic exp_err);
    int idx;
    int sh;
    logic [31:0] v;
    logic [31:0] mask;
    idx = int'((a >> 2) % DEPTH);
    sh  = 8 * int'(a % 4);
    exp_data = 32'h0;
    exp_err  = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    if (exp_err) return;
    if (wr) begin
      if (sz == 2'd2) begin
        mem_model[idx] = wd;
      end else begin
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        mem_model[idx] = (mem_model[idx] & ~mask) | ((wd << sh) & mask);
      end
    end else begin
      v = mem_model[idx] >> sh;
      if (sz == 2'd0) begin
        v = v & 32'hFF;
        if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      exp_data = v;
    end
  endfunction

  // Drives one request, keeps garbage on the request bus while busy, waits for the
  // response, holds it for 'hold' cycles, then accepts it.
  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                      input logic [1:0] sz, input logic uns, input int hold,
                      output logic [31:0] rd, output logic er, output int lat,
                      output logic got, output logic stable, output logic idle_after);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_addr = a; i_req_wdata = wd;
    i_req_write = wr; i_req_size = sz; i_req_unsigned = uns; i_rsp_ready = 1'b0;
    @(posedge i_clk); #1;
    i_req_addr = $urandom; i_req_wdata = $urandom; i_req_write = 1'($urandom);
    i_req_size = 2'($urandom); i_req_unsigned = 1'($urandom);
    lat = 0; got = 1'b0;
    while (lat < 20 && !got) begin
      @(posedge i_clk); #1;
      lat++;
      got = o_rsp_valid;
    end
    rd = o_rsp_rdata; er = o_rsp_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk); #1;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== rd || o_rsp_err !== er || o_req_ready !== 1'b0)
        stable = 1'b0;
    end
    i_rsp_ready = 1'b1; i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    idle_after = (o_rsp_valid === 1'b0) && (o_req_ready === 1'b1) && (o_busy === 1'b0);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req_valid = 1'b0; i_rsp_ready = 1'b0; i_req_addr = '0;
    i_req_wdata = '0; i_req_write = 1'b0; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    comp_cnt += 5;
    if (o_req_ready !== 1'b1) begin fail_cnt++; $display("FAIL reset_ready got=%b want=1", o_req_ready); end
    if (o_busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    if (o_rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid got=%b want=0", o_rsp_valid); end
    if (o_rsp_rdata !== 32'h0) begin fail_cnt++; $display("FAIL reset_rdata got=%h want=0", o_rsp_rdata); end
    if (o_rsp_err !== 1'b0) begin fail_cnt++; $display("FAIL reset_err got=%b want=0", o_rsp_err); end
    $display("reset: ready=%b busy=%b valid=%b", o_req_ready, o_busy, o_rsp_valid);
  endtask

  // One directed transaction with literal expectations, also mirrored in the model.
  task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] wd,
                             input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] want_data, input logic want_err);
    logic [31:0] rd, md; logic er, me, got, st, ia; int lat;
    model_op(a, wd, wr, sz, uns, md, me);
    xact(a, wd, wr, sz, uns, 0, rd, er, lat, got, st, ia);
    $display("%s: addr=%h wr=%b sz=%0d rdata=%h err=%b lat=%0d", name, a, wr, sz, rd, er, lat);
    comp_cnt += 4;
    if (!got || rd !== want_data || rd !== md) begin
      fail_cnt++; $display("FAIL %s_rdata got=%h want=%h", name, rd, want_data);
    end
    if (er !== want_err || er !== me) begin fail_cnt++; $display("FAIL %s_err got=%b want=%b", name, er, want_err); end
    if (!wr && !want_err && lat != 2) begin fail_cnt++; $display("FAIL %s_latency got=%0d want=2", name, lat); end
    if (!ia) begin fail_cnt++; $display("FAIL %s_idle_after got=0 want=1", name); end
  endtask

  task automatic test_fill();
    logic [31:0] rd, md; logic er, me, got, st, ia; int lat;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] wd;
      wd = $urandom;
      model_op(32'(i * 4), wd, 1'b1, 2'd2, 1'b0, md, me);
      xact(32'(i * 4), wd, 1'b1, 2'd2, 1'b0, 0, rd, er, lat, got, st, ia);
      $display("fill: addr=%h data=%h err=%b", i * 4, wd, er);
      comp_cnt++;
      if (!got || er !== 1'b0 || rd !== 32'h0) begin
        fail_cnt++; $display("FAIL fill_rsp got=%h/%b want=0/0", rd, er);
      end
    end
  endtask

  task automatic test_spec_vectors();
    test_vector("sw_word", 32'h10, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
    test_vector("lw_word", 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    test_vector("sb_80", 32'h11, 32'h00000080, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    test_vector("lb_11", 32'h11, 32'h0, 1'b0, 2'd0, 1'b0, 32'hFFFFFF80, 1'b0);
    test_vector("lbu_11", 32'h11, 32'h0, 1'b0, 2'd0, 1'b1, 32'h00000080, 1'b0);
    test_vector("lw_after_sb", 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 32'hDEAD80EF, 1'b0);
    test_vector("sh_8001", 32'h12, 32'h00008001, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
    test_vector("lh_12", 32'h12, 32'h0, 1'b0, 2'd1, 1'b0, 32'hFFFF8001, 1'b0);
    test_vector("lhu_12", 32'h12, 32'h0, 1'b0, 2'd1, 1'b1, 32'h00008001, 1'b0);
    test_vector("lh_13_mis", 32'h13, 32'h0, 1'b0, 2'd1, 1'b0, 32'h0, 1'b1);
    test_vector("lw_06_mis", 32'h06, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
    test_vector("sz11_store", 32'h10, 32'h11111111, 1'b1, 2'd3, 1'b0, 32'h0, 1'b1);
    test_vector("sw_06_mis", 32'h06, 32'h22222222, 1'b1, 2'd2, 1'b0, 32'h0, 1'b1);
    test_vector("lw_unchanged", 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 32'h800180EF, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, md; logic er, me, got, st, ia; int lat;
    model_op(32'h2010, 32'h0, 1'b0, 2'd2, 1'b0, md, me);
    xact(32'h2010, 32'h0, 1'b0, 2'd2, 1'b0, 5, rd, er, lat, got, st, ia);
    $display("backpressure: addr=2010 rdata=%h err=%b stable=%b", rd, er, st);
    comp_cnt += 3;
    if (!st) begin fail_cnt++; $display("FAIL hold_stable got=0 want=1"); end
    if (!got || rd !== 32'h800180EF || rd !== md) begin
      fail_cnt++; $display("FAIL alias_2010 got=%h want=800180ef", rd);
    end
    if (!ia) begin fail_cnt++; $display("FAIL hold_idle_after got=0 want=1"); end
  endtask

  task automatic test_reset_in_wr();
    logic [31:0] md; logic me;
    test_vector("sw_20_init", 32'h20, 32'h12345678, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_addr = 32'h20; i_req_wdata = 32'hCAFEF00D;
    i_req_write = 1'b1; i_req_size = 2'd2; i_req_unsigned = 1'b0;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    comp_cnt++;
    if (o_busy !== 1'b1) begin fail_cnt++; $display("FAIL wr_busy got=%b want=1", o_busy); end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    comp_cnt += 3;
    if (o_rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_wr_valid got=%b want=0", o_rsp_valid); end
    if (o_req_ready !== 1'b1) begin fail_cnt++; $display("FAIL rst_wr_ready got=%b want=1", o_req_ready); end
    if (o_busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_wr_busy got=%b want=0", o_busy); end
    repeat (2) @(posedge i_clk);
    #1;
    comp_cnt++;
    if (o_rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_wr_no_rsp got=%b want=0", o_rsp_valid); end
    $display("reset_in_wr: valid=%b ready=%b", o_rsp_valid, o_req_ready);
    md = 32'h0; me = 1'b0;
    test_vector("lw_20_kept", 32'h20, 32'h0, 1'b0, 2'd2, 1'b0, 32'h12345678, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] rd, md, a, wd; logic er, me, got, st, ia, wr, uns; logic [1:0] sz; int lat, hold;
    for (int n = 0; n < 200; n++) begin
      a   = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(0, 3));
      wd  = $urandom;
      wr  = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      hold = $urandom_range(0, 2);
      model_op(a, wd, wr, sz, uns, md, me);
      xact(a, wd, wr, sz, uns, hold, rd, er, lat, got, st, ia);
      $display("rand[%0d]: addr=%h wd=%h wr=%b sz=%0d u=%b rdata=%h err=%b lat=%0d",
               n, a, wd, wr, sz, uns, rd, er, lat);
      comp_cnt += 4;
      if (!got || rd !== md) begin fail_cnt++; $display("FAIL rand_rdata got=%h want=%h", rd, md); end
      if (er !== me) begin fail_cnt++; $display("FAIL rand_err got=%b want=%b", er, me); end
      if (!st || (!wr && !me && lat != 2)) begin
        fail_cnt++; $display("FAIL rand_timing got=lat%0d/stable%b want=lat2/stable1", lat, st);
      end
      if (!ia) begin fail_cnt++; $display("FAIL rand_idle_after got=0 want=1"); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_spec_vectors();
    test_backpressure();
    test_reset_in_wr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_data_responder.md
MEM_DATA_RESPONDER -- requirements
Module: mem_data_responder

Interface
REQ-001 SHALL have parameter LEN, default 32, meaning data and address width in bits.
REQ-002 SHALL have parameter RAM_DEPTH, default 2048, meaning number of LEN-bit words in the data RAM.
REQ-003 SHALL have parameter NB_SIZE, default 2, meaning access-size field width.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_req_valid, input, 1 bit: a request is present.
REQ-007 SHALL have port o_req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-008 SHALL have port i_req_addr, input, LEN bits: byte address.
REQ-009 SHALL have port i_req_wdata, input, LEN bits: store data, right-aligned for byte and half stores.
REQ-010 SHALL have port i_req_write, input, 1 bit: 1 for store, 0 for load.
REQ-011 SHALL have port i_req_size, input, NB_SIZE bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-012 SHALL have port i_req_unsigned, input, 1 bit: zero-extend loads instead of sign-extending them.
REQ-013 SHALL have port o_rsp_valid, output, 1 bit: a response is present.
REQ-014 SHALL have port i_rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-015 SHALL have port o_rsp_rdata, output, LEN bits: extended load data; 0 for stores and errors.
REQ-016 SHALL have port o_rsp_err, output, 1 bit: the request was misaligned or used reserved size 11.
REQ-017 SHALL have port o_busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, RD, WR and RSP.
REQ-019 SHALL drive o_req_ready=1 only in IDLE; a request is accepted when i_req_valid and o_req_ready are both 1 at a rising edge, and its fields are registered at that edge.
REQ-020 SHALL decode the word index as i_req_addr[log2(RAM_DEPTH)+1:2]; upper address bits are ignored, so addresses wrap.
REQ-021 SHALL use little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
REQ-022 SHALL treat a request as misaligned when size=01 and addr[0]=1, or size=10 and addr[1:0]!=0, or size=11; such a request goes IDLE->RSP with err=1, rdata=0 and no RAM access.
REQ-023 SHALL sequence a load as IDLE->RD (RAM read, 1-cycle latency)->RSP; o_rsp_valid rises 2 cycles after the accept edge.
REQ-024 SHALL return load data as follows: byte lane extended by bit 7 of that lane, half lane extended by bit 15 of that lane, or zero-extended when unsigned; word loads are returned unchanged.
REQ-025 SHALL sequence a word store as IDLE->WR (full-word write)->RSP.
REQ-026 SHALL sequence a byte or half store as IDLE->RD->WR, writing the old word with only the addressed lane replaced by the low bits of wdata, then ->RSP.
REQ-027 SHALL hold o_rsp_valid, o_rsp_rdata and o_rsp_err stable in RSP until i_rsp_ready=1, then go to IDLE; a new request is never accepted in the same cycle a response is accepted.
REQ-028 SHALL assert the RAM write enable only in WR, and enable the RAM only in RD or WR.
REQ-029 SHALL ignore changes on i_req_* while not in IDLE.

Reset
REQ-030 SHALL, while i_rst=1 at a clock edge, set the state to IDLE, o_rsp_valid=0, o_rsp_rdata=0 and o_rsp_err=0; o_req_ready then reads 1 and o_busy reads 0.
REQ-031 SHALL make reset take priority over every transition: a reset in a WR cycle suppresses the write, and a reset in RSP drops the response.

Structure
REQ-032 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and the FSM state encodings in the shared MIPS package.
REQ-033 SHALL instantiate the existing single-port RAM ram_datos (LOW_LATENCY, RAM_WIDTH=LEN, RAM_DEPTH=RAM_DEPTH) as its only sub-module; lane merge and extension logic stays local.

Verification
REQ-034 SHALL cover: store word 0xDEADBEEF at addr 0x10, then load word at 0x10 -> rsp rdata=0xDEADBEEF, err=0, valid 2 cycles after the load is accepted.
REQ-035 SHALL cover: store byte 0x80 at addr 0x11, then LB at 0x11 -> 0xFFFFFF80, LBU at 0x11 -> 0x00000080, and load word at 0x10 -> 0xDEAD80EF.
REQ-036 SHALL cover: store half 0x8001 at addr 0x12, then LH at 0x12 -> 0xFFFF8001, LHU -> 0x00008001.
REQ-037 SHALL cover: LH at 0x13, load word at 0x06, and size=11 -> err=1, rdata=0, RAM contents unchanged.
REQ-038 SHALL cover: i_rsp_ready held 0 for 5 cycles -> response stable and o_req_ready=0 throughout; and addr 0x2010 with RAM_DEPTH=2048 aliases to 0x10.
REQ-039 SHALL cover: i_rst=1 during the WR cycle of a store to 0x20 -> word at 0x20 unchanged, state IDLE, o_rsp_valid=0.
